// File: rtl/mul_pkg.sv
// Shared types for the sequential shift-add multiplier.
package mul_pkg;

  // Operation select: which half of the product, and which operands are signed.
  typedef enum logic [1:0] {
    OP_MUL    = 2'b00,  // low half (signedness irrelevant)
    OP_MULH   = 2'b01,  // signed x signed, high half
    OP_MULHSU = 2'b10,  // signed A x unsigned B, high half
    OP_MULHU  = 2'b11   // unsigned x unsigned, high half
  } mul_op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_DONE = 2'b10
  } mul_state_t;

  // Operand A is interpreted as two's complement for MULH and MULHSU.
  function automatic logic op_a_signed(input mul_op_t o);
    return (o == OP_MULH) || (o == OP_MULHSU);
  endfunction

  // Operand B is interpreted as two's complement only for MULH.
  function automatic logic op_b_signed(input mul_op_t o);
    return (o == OP_MULH);
  endfunction

endpackage

// File: rtl/mul_sign_fix.sv
// Conditional two's-complement negate. Used both to take operand
// magnitudes at capture and to restore the product sign at the end.
// The magnitude of the most-negative value comes out as the same bit
// pattern, which is correct when the result is read as unsigned.
module mul_sign_fix #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] mag_i,
  input  logic             neg_i,
  output logic [WIDTH-1:0] val_o
);

  // Negate when requested, otherwise pass through.
  assign val_o = neg_i ? (-mag_i) : mag_i;

endmodule

// File: rtl/multiplier.sv
// Sequential radix-2 shift-add multiplier with RISC-V style op select.
// DATA_WIDTH must be even and at least 4.
//
//  state   | meaning
//  --------+-----------------------------------------------------------
//  IDLE    | waiting for data_valid; ready high
//  BUSY    | one shift-add iteration per cycle, then one finishing cycle
//  DONE    | out_valid high, Result updated; a new strobe is accepted
module multiplier
  import mul_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic                  data_valid,
  input  logic [1:0]            op,
  input  logic [DATA_WIDTH-1:0] Multiplicand,
  input  logic [DATA_WIDTH-1:0] Multiplier,
  output logic                  ready,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] Result
);

  localparam int W  = DATA_WIDTH;
  localparam int PW = 2 * DATA_WIDTH;
  localparam int CW = $clog2(DATA_WIDTH + 1);

  mul_state_t       state_q;
  logic [CW-1:0]    count_q;
  logic [PW-1:0]    acc_q;
  logic [PW-1:0]    mcand_q;
  logic [W-1:0]     mplier_q;
  logic             neg_q;
  mul_op_t          op_q;
  logic             out_valid_q;
  logic [W-1:0]     result_q;

  mul_op_t          op_in;
  logic             a_neg_d;
  logic             b_neg_d;
  logic [W-1:0]     mag_a_d;
  logic [W-1:0]     mag_b_d;
  logic [PW-1:0]    acc_d;
  logic [PW-1:0]    product_d;
  logic [W-1:0]     result_d;

  // Operand sign detection depends on the requested op.
  assign op_in   = mul_op_t'(op);
  assign a_neg_d = op_a_signed(op_in) & Multiplicand[W-1];
  assign b_neg_d = op_b_signed(op_in) & Multiplier[W-1];

  mul_sign_fix #(.WIDTH(W)) u_abs_a (
    .mag_i (Multiplicand),
    .neg_i (a_neg_d),
    .val_o (mag_a_d)
  );

  mul_sign_fix #(.WIDTH(W)) u_abs_b (
    .mag_i (Multiplier),
    .neg_i (b_neg_d),
    .val_o (mag_b_d)
  );

  mul_sign_fix #(.WIDTH(PW)) u_fix_prod (
    .mag_i (acc_q),
    .neg_i (neg_q),
    .val_o (product_d)
  );

  // Next accumulator value for one shift-add step, and the selected result half.
  always_comb begin
    acc_d    = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
    result_d = (op_q == OP_MUL) ? product_d[W-1:0] : product_d[PW-1:W];
  end

  // Control FSM and datapath registers; outputs are registered here.
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      state_q     <= ST_IDLE;
      count_q     <= '0;
      acc_q       <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      neg_q       <= 1'b0;
      op_q        <= OP_MUL;
      out_valid_q <= 1'b0;
      result_q    <= '0;
    end else begin
      out_valid_q <= 1'b0;
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (data_valid) begin
            acc_q    <= '0;
            mcand_q  <= {{W{1'b0}}, mag_a_d};
            mplier_q <= mag_b_d;
            neg_q    <= a_neg_d ^ b_neg_d;
            op_q     <= op_in;
            count_q  <= '0;
            state_q  <= ST_BUSY;
          end else begin
            state_q  <= ST_IDLE;
          end
        end
        ST_BUSY: begin
          if (count_q == CW'(W)) begin
            // All iterations done: apply sign and publish.
            result_q    <= result_d;
            out_valid_q <= 1'b1;
            state_q     <= ST_DONE;
          end else begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            count_q  <= count_q + CW'(1);
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign ready     = (state_q == ST_IDLE) || (state_q == ST_DONE);
  assign out_valid = out_valid_q;
  assign Result    = result_q;

endmodule

// File: tb/tb_multiplier.sv
// Self-checking bench for multiplier at DATA_WIDTH=8.
module tb_multiplier;

  localparam int W = 8;

  logic         Clk;
  logic         Rst;
  logic         data_valid;
  logic [1:0]   op;
  logic [W-1:0] mcand;
  logic [W-1:0] mplier;
  logic         ready;
  logic         out_valid;
  logic [W-1:0] Result;

  int n_cmp = 0;
  int n_err = 0;
  logic prev_ov = 1'b0;

  multiplier #(.DATA_WIDTH(W)) dut (
    .Clk          (Clk),
    .Rst          (Rst),
    .data_valid   (data_valid),
    .op           (op),
    .Multiplicand (mcand),
    .Multiplier   (mplier),
    .ready        (ready),
    .out_valid    (out_valid),
    .Result       (Result)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: plain integer multiplication of the operands as the op interprets them.
  function automatic logic [W-1:0] ref_mul(input logic [1:0] o, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
    longint va, vb, p;
    va = longint'(a);
    vb = longint'(b);
    if ((o == 2'd1 || o == 2'd2) && a[W-1]) va = va - (longint'(1) << W);
    if ((o == 2'd1) && b[W-1]) vb = vb - (longint'(1) << W);
    p = va * vb;
    return (o == 2'd0) ? p[W-1:0] : p[2*W-1:W];
  endfunction

  // out_valid must never be high on two consecutive cycles.
  always @(negedge Clk) begin
    if (out_valid) begin
      n_cmp++;
      if (prev_ov) begin
        n_err++;
        $display("FAIL out_valid_double: got 1 on consecutive cycles, expected single pulse");
      end
    end
    prev_ov = out_valid;
  end

  // Called #1 after an edge with the DUT ready; returns #1 after the accepting edge.
  task automatic issue(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    op         = o;
    mcand      = a;
    mplier     = b;
    data_valid = 1'b1;
    @(posedge Clk);
    #1;
    data_valid = 1'b0;
  endtask

  // Waits for out_valid; 'skip' edges since acceptance have already elapsed.
  task automatic await(input string name, input logic [W-1:0] exp, input int skip);
    int   k;
    logic rdy_bad;
    rdy_bad = 1'b0;
    for (k = skip + 1; k <= 20; k++) begin
      @(posedge Clk);
      #1;
      if (out_valid) break;
      if (ready) rdy_bad = 1'b1;
    end
    check({name, "_latency"}, k, W + 1);
    check({name, "_result"}, Result, exp);
    check({name, "_ready_busy"}, rdy_bad, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[8];
    vecs[0] = '{2'd0, 8'h48, 8'h18, 8'hC0};
    vecs[1] = '{2'd3, 8'h48, 8'h18, 8'h06};
    vecs[2] = '{2'd0, 8'hF9, 8'hFD, 8'h15};
    vecs[3] = '{2'd1, 8'hF9, 8'hFD, 8'h00};
    vecs[4] = '{2'd2, 8'hFF, 8'hFF, 8'hFF};
    vecs[5] = '{2'd1, 8'h80, 8'h80, 8'h40};
    vecs[6] = '{2'd0, 8'h5A, 8'h00, 8'h00};
    vecs[7] = '{2'd3, 8'h00, 8'hFF, 8'h00};

    Rst = 1'b0; data_valid = 1'b0; op = 2'd0; mcand = '0; mplier = '0;
    repeat (2) @(posedge Clk);
    #1;
    check("reset_ready", ready, 1'b1);
    check("reset_out_valid", out_valid, 1'b0);
    check("reset_result", Result, 8'h00);
    Rst = 1'b1;
    @(posedge Clk);
    #1;

    for (int i = 0; i < 8; i++) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b);
      await($sformatf("vec%0d", i), vecs[i].exp, 0);
      @(posedge Clk);
      #1;
      check($sformatf("vec%0d_idle_ready", i), ready, 1'b1);
      check($sformatf("vec%0d_hold", i), Result, vecs[i].exp);
    end

    // Strobe and operand changes while busy are ignored.
    issue(2'd0, 8'h48, 8'h18);
    @(posedge Clk); #1;
    @(posedge Clk); #1;
    op = 2'd2; mcand = 8'hFF; mplier = 8'hFF; data_valid = 1'b1;
    @(posedge Clk); #1;
    data_valid = 1'b0;
    await("busy_ignore", 8'hC0, 3);

    // Back-to-back: accept in the DONE cycle.
    issue(2'd3, 8'h48, 8'h18);
    check("b2b_hold_result", Result, 8'hC0);
    check("b2b_no_valid", out_valid, 1'b0);
    await("b2b_second", 8'h06, 0);

    // Reset four edges into BUSY abandons the operation.
    @(posedge Clk); #1;
    issue(2'd3, 8'hFF, 8'hFF);
    repeat (3) begin @(posedge Clk); #1; end
    Rst = 1'b0;
    @(posedge Clk); #1;
    check("midreset_ready", ready, 1'b1);
    check("midreset_out_valid", out_valid, 1'b0);
    check("midreset_result", Result, 8'h00);
    Rst = 1'b1;
    issue(2'd0, 8'h48, 8'h18);
    await("after_reset", 8'hC0, 0);

    // Randomized operations against the arithmetic reference.
    for (int i = 0; i < 1000; i++) begin
      logic [1:0]   o;
      logic [W-1:0] a, b;
      o = 2'($urandom_range(0, 3));
      a = 8'($urandom);
      b = 8'($urandom);
      if ($urandom_range(0, 7) == 0) a = 8'h80;
      if ($urandom_range(0, 7) == 0) b = ($urandom_range(0, 1) != 0) ? 8'h80 : 8'hFF;
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 3)) begin @(posedge Clk); #1; end
        check("rand_idle_ready", ready, 1'b1);
      end
      issue(o, a, b);
      await($sformatf("rand%0d_op%0d_%02h_%02h", i, o, a, b), ref_mul(o, a, b), 0);
    end

    @(posedge Clk); #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
